// File: rtl/rob_retire_controller.sv
// In-order retirement tracker for the 2-wide rename stage: records superseded physical
// registers per ROB entry and hands them back to the renamer's free pool only at commit.
module rob_retire_controller #(
  parameter int NUM_P_REGS = 64,
  parameter int ROB_DEPTH  = 16,
  localparam int PW = $clog2(NUM_P_REGS),
  localparam int TW = $clog2(ROB_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          alloc0_valid_i,
  input  logic          alloc1_valid_i,
  input  logic          alloc0_has_dest_i,
  input  logic          alloc1_has_dest_i,
  input  logic [PW-1:0] alloc0_old_preg_i,
  input  logic [PW-1:0] alloc1_old_preg_i,
  output logic          alloc_ready_o,
  output logic [TW-1:0] alloc0_tag_o,
  output logic [TW-1:0] alloc1_tag_o,
  input  logic          complete0_valid_i,
  input  logic          complete1_valid_i,
  input  logic [TW-1:0] complete0_tag_i,
  input  logic [TW-1:0] complete1_tag_i,
  input  logic          flush_i,
  output logic          en_free_reg0_o,
  output logic          en_free_reg1_o,
  output logic [PW-1:0] free_reg0_o,
  output logic [PW-1:0] free_reg1_o,
  output logic [1:0]    retire_count_o,
  output logic [TW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [TW-1:0] head_q, head_d, tail_q, tail_d;
  logic [TW:0]   count_q, count_d;
  logic          valid_q    [ROB_DEPTH];
  logic          done_q     [ROB_DEPTH];
  logic          has_dest_q [ROB_DEPTH];
  logic [PW-1:0] old_preg_q [ROB_DEPTH];

  logic          en_free0_q, en_free1_q, en_free0_d, en_free1_d;
  logic [PW-1:0] free_reg0_q, free_reg1_q;
  logic [1:0]    retire_count_q;

  logic [TW-1:0] head1, tail1;
  logic          accept0, accept1, retire0, retire1;
  logic [1:0]    num_acc, num_ret;

  assign head1         = head_q + TW'(1);
  assign tail1         = tail_q + TW'(1);
  assign alloc_ready_o = (count_q <= (TW+1)'(ROB_DEPTH - 2));
  assign alloc0_tag_o  = tail_q;
  assign alloc1_tag_o  = alloc0_valid_i ? tail1 : tail_q;

  // Retirement looks only at pre-edge state, so a same-cycle completion waits one edge.
  always_comb begin
    accept0    = ~flush_i & alloc_ready_o & alloc0_valid_i;
    accept1    = ~flush_i & alloc_ready_o & alloc1_valid_i;
    retire0    = ~flush_i & valid_q[head_q] & done_q[head_q];
    retire1    = retire0 & valid_q[head1] & done_q[head1];
    num_acc    = {1'b0, accept0} + {1'b0, accept1};
    num_ret    = {1'b0, retire0} + {1'b0, retire1};
    en_free0_d = retire0 & has_dest_q[head_q] & (old_preg_q[head_q] != '0);
    en_free1_d = retire1 & has_dest_q[head1] & (old_preg_q[head1] != '0);
    head_d     = head_q + TW'(num_ret);
    tail_d     = tail_q + TW'(num_acc);
    count_d    = count_q + (TW+1)'(num_acc) - (TW+1)'(num_ret);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      en_free0_q     <= 1'b0;
      en_free1_q     <= 1'b0;
      free_reg0_q    <= '0;
      free_reg1_q    <= '0;
      retire_count_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        valid_q[i]    <= 1'b0;
        done_q[i]     <= 1'b0;
        has_dest_q[i] <= 1'b0;
        old_preg_q[i] <= '0;
      end
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      en_free0_q     <= en_free0_d;
      en_free1_q     <= en_free1_d;
      free_reg0_q    <= old_preg_q[head_q];
      free_reg1_q    <= old_preg_q[head1];
      retire_count_q <= num_ret;
      if (flush_i) begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
          valid_q[i] <= 1'b0;
          done_q[i]  <= 1'b0;
        end
      end else begin
        if (complete0_valid_i && valid_q[complete0_tag_i]) done_q[complete0_tag_i] <= 1'b1;
        if (complete1_valid_i && valid_q[complete1_tag_i]) done_q[complete1_tag_i] <= 1'b1;
        if (retire0) begin
          valid_q[head_q] <= 1'b0;
          done_q[head_q]  <= 1'b0;
        end
        if (retire1) begin
          valid_q[head1] <= 1'b0;
          done_q[head1]  <= 1'b0;
        end
        // Accepted slots always land on free entries because at least two are empty.
        if (accept0) begin
          valid_q[tail_q]    <= 1'b1;
          done_q[tail_q]     <= 1'b0;
          has_dest_q[tail_q] <= alloc0_has_dest_i;
          old_preg_q[tail_q] <= alloc0_old_preg_i;
        end
        if (accept1) begin
          valid_q[alloc1_tag_o]    <= 1'b1;
          done_q[alloc1_tag_o]     <= 1'b0;
          has_dest_q[alloc1_tag_o] <= alloc1_has_dest_i;
          old_preg_q[alloc1_tag_o] <= alloc1_old_preg_i;
        end
      end
    end
  end

  assign en_free_reg0_o = en_free0_q;
  assign en_free_reg1_o = en_free1_q;
  assign free_reg0_o    = free_reg0_q;
  assign free_reg1_o    = free_reg1_q;
  assign retire_count_o = retire_count_q;
  assign count_o        = count_q;
  assign empty_o        = (count_q == '0);
  assign full_o         = (count_q == (TW+1)'(ROB_DEPTH));

endmodule

// File: tb/tb_rob_retire_controller.sv
// Directed bench for rob_retire_controller; allocations push expected frees to a
// scoreboard queue that is drained whenever the DUT reports retirements.
module tb_rob_retire_controller;
  localparam int PW = 6;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc0_valid_i, alloc1_valid_i, alloc0_has_dest_i, alloc1_has_dest_i;
  logic [PW-1:0] alloc0_old_preg_i, alloc1_old_preg_i;
  logic          alloc_ready_o;
  logic [TW-1:0] alloc0_tag_o, alloc1_tag_o;
  logic          complete0_valid_i, complete1_valid_i;
  logic [TW-1:0] complete0_tag_i, complete1_tag_i;
  logic          flush_i;
  logic          en_free_reg0_o, en_free_reg1_o;
  logic [PW-1:0] free_reg0_o, free_reg1_o;
  logic [1:0]    retire_count_o;
  logic [TW:0]   count_o;
  logic          empty_o, full_o;

  typedef struct packed {
    logic          hd;
    logic [PW-1:0] preg;
  } sb_t;

  sb_t           sbq[$];
  int            checks = 0;
  int            passes = 0;
  logic [TW-1:0] mtail, cptr, t;

  rob_retire_controller #(.NUM_P_REGS(64), .ROB_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc0_valid_i(alloc0_valid_i), .alloc1_valid_i(alloc1_valid_i),
    .alloc0_has_dest_i(alloc0_has_dest_i), .alloc1_has_dest_i(alloc1_has_dest_i),
    .alloc0_old_preg_i(alloc0_old_preg_i), .alloc1_old_preg_i(alloc1_old_preg_i),
    .alloc_ready_o(alloc_ready_o), .alloc0_tag_o(alloc0_tag_o), .alloc1_tag_o(alloc1_tag_o),
    .complete0_valid_i(complete0_valid_i), .complete1_valid_i(complete1_valid_i),
    .complete0_tag_i(complete0_tag_i), .complete1_tag_i(complete1_tag_i),
    .flush_i(flush_i),
    .en_free_reg0_o(en_free_reg0_o), .en_free_reg1_o(en_free_reg1_o),
    .free_reg0_o(free_reg0_o), .free_reg1_o(free_reg1_o),
    .retire_count_o(retire_count_o), .count_o(count_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes = passes + 1;
    end else begin
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    alloc0_valid_i = 0; alloc1_valid_i = 0; alloc0_has_dest_i = 0; alloc1_has_dest_i = 0;
    alloc0_old_preg_i = '0; alloc1_old_preg_i = '0;
    complete0_valid_i = 0; complete1_valid_i = 0; complete0_tag_i = '0; complete1_tag_i = '0;
    flush_i = 0;
  endtask

  // Drives an allocation; when it should be accepted the expected frees join the queue in program order.
  task automatic applyStimulus(input logic v0, input logic h0, input logic [PW-1:0] p0,
                               input logic v1, input logic h1, input logic [PW-1:0] p1,
                               input bit accept);
    alloc0_valid_i = v0; alloc0_has_dest_i = h0; alloc0_old_preg_i = p0;
    alloc1_valid_i = v1; alloc1_has_dest_i = h1; alloc1_old_preg_i = p1;
    if (accept) begin
      if (v0) begin sbq.push_back('{hd: h0, preg: p0}); mtail = mtail + 1'b1; end
      if (v1) begin sbq.push_back('{hd: h1, preg: p1}); mtail = mtail + 1'b1; end
    end
  endtask

  task automatic setComplete(input logic v0, input logic [TW-1:0] t0,
                             input logic v1, input logic [TW-1:0] t1);
    complete0_valid_i = v0; complete0_tag_i = t0;
    complete1_valid_i = v1; complete1_tag_i = t1;
  endtask

  task automatic checkRetire();
    sb_t  e;
    logic expEn;
    int   n;
    n = int'(retire_count_o);
    for (int k = 0; k < 2; k++) begin
      if (k < n) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_underflow", 0, 1);
        end else begin
          e = sbq.pop_front();
          expEn = e.hd && (e.preg != '0);
          checkOutput(k == 0 ? "free_en0" : "free_en1", k == 0 ? en_free_reg0_o : en_free_reg1_o, expEn);
          if (expEn)
            checkOutput(k == 0 ? "free_reg0" : "free_reg1", k == 0 ? free_reg0_o : free_reg1_o, e.preg);
        end
      end else begin
        checkOutput(k == 0 ? "idle_en0" : "idle_en1", k == 0 ? en_free_reg0_o : en_free_reg1_o, 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkRetire();
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    mtail = '0;
    cptr  = '0;
    #12;
    checkOutput("rst_count", count_o, 0);
    checkOutput("rst_empty", empty_o, 1);
    checkOutput("rst_full", full_o, 0);
    checkOutput("rst_ready", alloc_ready_o, 1);
    checkOutput("rst_en0", en_free_reg0_o, 0);
    checkOutput("rst_en1", en_free_reg1_o, 0);
    checkOutput("rst_retcnt", retire_count_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Pair allocation, out-of-order completion, in-order retirement
    applyStimulus(1, 1, 6'd5, 1, 1, 6'd7, 1);
    #1;
    checkOutput("pair_tag0", alloc0_tag_o, 0);
    checkOutput("pair_tag1", alloc1_tag_o, 1);
    tick(); clearInputs();
    checkOutput("pair_count", count_o, 2);
    setComplete(1, 4'd1, 0, 4'd0);
    tick(); clearInputs();
    tick();
    checkOutput("younger_done_no_retire", retire_count_o, 0);
    checkOutput("younger_done_count", count_o, 2);
    setComplete(1, 4'd0, 0, 4'd0);
    tick(); clearInputs();
    checkOutput("completion_not_visible", retire_count_o, 0);
    tick();
    checkOutput("pair_retcnt", retire_count_o, 2);
    checkOutput("pair_en0", en_free_reg0_o, 1);
    checkOutput("pair_en1", en_free_reg1_o, 1);
    checkOutput("pair_free0", free_reg0_o, 5);
    checkOutput("pair_free1", free_reg1_o, 7);
    checkOutput("pair_empty", empty_o, 1);
    tick();
    checkOutput("strobe_single_cycle", en_free_reg0_o, 0);
    checkOutput("retcnt_clears", retire_count_o, 0);

    // Lone slot-1 allocation takes the tail index
    applyStimulus(0, 0, 6'd0, 1, 1, 6'd9, 1);
    #1;
    checkOutput("lone_slot1_tag", alloc1_tag_o, 2);
    tick(); clearInputs();
    setComplete(1, 4'd2, 0, 4'd0);
    tick(); clearInputs();
    tick();
    checkOutput("lone_retcnt", retire_count_o, 1);
    checkOutput("lone_free0", free_reg0_o, 9);

    // No-destination entry retires silently
    applyStimulus(1, 0, 6'd0, 0, 0, 6'd0, 1);
    #1;
    checkOutput("nodest_tag", alloc0_tag_o, 3);
    tick(); clearInputs();
    setComplete(1, 4'd3, 0, 4'd0);
    tick(); clearInputs();
    tick();
    checkOutput("nodest_retcnt", retire_count_o, 1);
    checkOutput("nodest_en0", en_free_reg0_o, 0);

    // Fill to 15, rejected allocation, then free one slot and fill to 16
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 1, PW'(20 + 2 * i), 1, 1, PW'(21 + 2 * i), 1);
      tick();
    end
    applyStimulus(1, 1, 6'd0, 0, 0, 6'd0, 1);
    tick(); clearInputs();
    checkOutput("fill_count", count_o, 15);
    checkOutput("fill_ready", alloc_ready_o, 0);
    checkOutput("fill_not_full", full_o, 0);
    applyStimulus(1, 1, 6'd1, 1, 1, 6'd2, 0);
    tick(); clearInputs();
    checkOutput("alloc_ignored", count_o, 15);
    cptr = 4'd4;
    setComplete(1, cptr, 0, 4'd0);
    cptr = cptr + 1'b1;
    tick(); clearInputs();
    tick();
    checkOutput("head_retire_retcnt", retire_count_o, 1);
    checkOutput("head_retire_count", count_o, 14);
    checkOutput("head_retire_ready", alloc_ready_o, 1);
    applyStimulus(1, 1, 6'd36, 1, 1, 6'd37, 1);
    #1;
    checkOutput("refill_tag0", alloc0_tag_o, 3);
    checkOutput("refill_tag1", alloc1_tag_o, 4);
    tick(); clearInputs();
    checkOutput("full_count", count_o, 16);
    checkOutput("full_flag", full_o, 1);
    checkOutput("full_ready", alloc_ready_o, 0);

    // Drain the full buffer
    for (int i = 0; i < 8; i++) begin
      setComplete(1, cptr, 1, cptr + 4'd1);
      cptr = cptr + 4'd2;
      tick();
    end
    clearInputs();
    for (int c = 0; c < 40 && empty_o !== 1'b1; c++) tick();
    checkOutput("drain_empty", empty_o, 1);
    checkOutput("sb_drained", sbq.size(), 0);

    // Walk head up to 15 so the next pair straddles the wrap
    for (int i = 0; i < 16 && mtail != 4'd15; i++) begin
      t = mtail;
      applyStimulus(1, 1, PW'(30 + i), 0, 0, 6'd0, 1);
      tick(); clearInputs();
      setComplete(1, t, 0, 4'd0);
      tick(); clearInputs();
      tick();
    end
    checkOutput("walk_count", count_o, 0);
    applyStimulus(1, 1, 6'd40, 1, 1, 6'd41, 1);
    #1;
    checkOutput("wrap_tag0", alloc0_tag_o, 15);
    checkOutput("wrap_tag1", alloc1_tag_o, 0);
    tick(); clearInputs();
    setComplete(1, 4'd15, 1, 4'd0);
    tick(); clearInputs();
    tick();
    checkOutput("wrap_retcnt", retire_count_o, 2);
    checkOutput("wrap_free0", free_reg0_o, 40);
    checkOutput("wrap_free1", free_reg1_o, 41);
    checkOutput("wrap_count", count_o, 0);

    // Flush with six pending entries, three done but not at the head
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, PW'(50 + 2 * i), 1, 1, PW'(51 + 2 * i), 1);
      tick();
    end
    clearInputs();
    setComplete(1, 4'd2, 1, 4'd3);
    tick();
    setComplete(1, 4'd4, 1, 4'd4);
    tick(); clearInputs();
    tick();
    checkOutput("preflush_count", count_o, 6);
    checkOutput("preflush_retcnt", retire_count_o, 0);
    flush_i = 1'b1;
    applyStimulus(1, 1, 6'd1, 1, 1, 6'd2, 0);
    setComplete(1, 4'd1, 0, 4'd0);
    sbq.delete();
    mtail = '0;
    tick(); clearInputs();
    checkOutput("flush_count", count_o, 0);
    checkOutput("flush_empty", empty_o, 1);
    checkOutput("flush_en0", en_free_reg0_o, 0);
    checkOutput("flush_en1", en_free_reg1_o, 0);
    checkOutput("flush_retcnt", retire_count_o, 0);
    #1;
    checkOutput("flush_next_tag", alloc0_tag_o, 0);
    tick();
    checkOutput("flush_stays_empty", count_o, 0);

    // Asynchronous reset drops a live free strobe
    applyStimulus(1, 1, 6'd60, 0, 0, 6'd0, 1);
    tick(); clearInputs();
    setComplete(1, 4'd0, 0, 4'd0);
    tick(); clearInputs();
    tick();
    checkOutput("prereset_en0", en_free_reg0_o, 1);
    checkOutput("prereset_free0", free_reg0_o, 60);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_en0", en_free_reg0_o, 0);
    checkOutput("async_rst_free0", free_reg0_o, 0);
    checkOutput("async_rst_retcnt", retire_count_o, 0);
    checkOutput("async_rst_count", count_o, 0);
    checkOutput("async_rst_ready", alloc_ready_o, 1);
    sbq.delete();
    mtail = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_count", count_o, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
